// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge: executes decoded UART commands against instruction/data memory.
// Writes issue a single-cycle strobe; reads fetch one word and stream it back
// MSB byte first over a tx_start/tx_done byte handshake.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   S_IDLE      | ready for a command; cmd_valid latches addr/wdata/mem_type
//   S_WRITE     | one cycle, imem_we or dmem_we asserted
//   S_READ_REQ  | one cycle, imem_re or dmem_re asserted; latency timer loaded
//   S_READ_WAIT | timer counting down; at terminal count capture read data
//   S_TX_SEND   | one cycle, tx_start asserted with current byte on tx_data
//   S_TX_WAIT   | waiting for tx_done; advance byte or return to idle
//
// Every output is a register. The always_comb block computes the value each
// output should take in the next state, so strobes line up with the state they
// belong to (e.g. the write strobe is high while the FSM sits in S_WRITE).
module uart_mem_bridge #(
  parameter int ADDR_WIDTH     = 9,
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_COUNT     = 4,
  parameter int MEM_RD_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_cmd_valid,
  input  logic                  i_cmd_rw,
  input  logic                  i_cmd_mem_type,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
  output logic                  o_cmd_ready,
  output logic                  o_cmd_dropped,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_imem_we,
  output logic                  o_dmem_we,
  output logic                  o_imem_re,
  output logic                  o_dmem_re,
  input  logic [DATA_WIDTH-1:0] i_imem_rdata,
  input  logic [DATA_WIDTH-1:0] i_dmem_rdata,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_start,
  input  logic                  i_tx_done,
  output logic                  o_busy
);

  localparam int                CNT_W    = (BYTE_COUNT > 1) ? $clog2(BYTE_COUNT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BYTE_COUNT - 1);
  // Timer is loaded with latency-1 so its terminal count lands exactly
  // MEM_RD_LATENCY cycles after the read-strobe cycle.
  localparam logic [2:0]        LAT_LOAD = 3'(MEM_RD_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ_REQ,
    S_READ_WAIT,
    S_TX_SEND,
    S_TX_WAIT
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_mem_type, w_mem_type_nxt;
  logic [CNT_W-1:0]      r_byte_cnt, w_byte_cnt_nxt;
  logic [2:0]            r_lat_cnt, w_lat_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_word, w_word_nxt;
  logic [DATA_WIDTH-1:0] w_rdata_sel;

  logic                  r_cmd_ready, w_cmd_ready_nxt;
  logic                  r_cmd_dropped, w_cmd_dropped_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic                  r_imem_we, w_imem_we_nxt;
  logic                  r_dmem_we, w_dmem_we_nxt;
  logic                  r_imem_re, w_imem_re_nxt;
  logic                  r_dmem_re, w_dmem_re_nxt;
  logic [7:0]            r_tx_data, w_tx_data_nxt;
  logic                  r_tx_start, w_tx_start_nxt;
  logic                  r_busy, w_busy_nxt;

  // Byte idx of a word, counted from the most significant byte.
  function automatic logic [7:0] byte_of(input logic [DATA_WIDTH-1:0] word,
                                         input logic [CNT_W-1:0]      idx);
    logic [7:0] res;
    res = '0;
    for (int b = 0; b < BYTE_COUNT; b++) begin
      if (idx == CNT_W'(b)) res = word[(BYTE_COUNT-1-b)*8 +: 8];
    end
    return res;
  endfunction

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt       = r_state;
    w_mem_type_nxt    = r_mem_type;
    w_byte_cnt_nxt    = r_byte_cnt;
    w_lat_cnt_nxt     = r_lat_cnt;
    w_word_nxt        = r_word;
    w_mem_addr_nxt    = r_mem_addr;
    w_mem_wdata_nxt   = r_mem_wdata;
    w_tx_data_nxt     = r_tx_data;
    w_imem_we_nxt     = 1'b0;
    w_dmem_we_nxt     = 1'b0;
    w_imem_re_nxt     = 1'b0;
    w_dmem_re_nxt     = 1'b0;
    w_tx_start_nxt    = 1'b0;
    w_cmd_dropped_nxt = i_cmd_valid && (r_state != S_IDLE);
    w_rdata_sel       = r_mem_type ? i_dmem_rdata : i_imem_rdata;

    case (r_state)
      S_IDLE: begin
        if (i_cmd_valid) begin
          w_mem_type_nxt  = i_cmd_mem_type;
          w_mem_addr_nxt  = i_cmd_addr;
          w_mem_wdata_nxt = i_cmd_wdata;
          if (i_cmd_rw) begin
            w_state_nxt   = S_WRITE;
            w_imem_we_nxt = !i_cmd_mem_type;
            w_dmem_we_nxt = i_cmd_mem_type;
          end else begin
            w_state_nxt   = S_READ_REQ;
            w_imem_re_nxt = !i_cmd_mem_type;
            w_dmem_re_nxt = i_cmd_mem_type;
          end
        end
      end
      S_WRITE: begin
        w_state_nxt = S_IDLE;
      end
      S_READ_REQ: begin
        w_lat_cnt_nxt = LAT_LOAD;
        w_state_nxt   = S_READ_WAIT;
      end
      S_READ_WAIT: begin
        if (r_lat_cnt == 3'd0) begin
          w_word_nxt     = w_rdata_sel;
          w_byte_cnt_nxt = '0;
          w_tx_data_nxt  = byte_of(w_rdata_sel, '0);
          w_tx_start_nxt = 1'b1;
          w_state_nxt    = S_TX_SEND;
        end else begin
          w_lat_cnt_nxt = r_lat_cnt - 3'd1;
        end
      end
      S_TX_SEND: begin
        w_state_nxt = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (i_tx_done) begin
          if (r_byte_cnt == CNT_LAST) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_byte_cnt_nxt = r_byte_cnt + 1'b1;
            w_tx_data_nxt  = byte_of(r_word, r_byte_cnt + 1'b1);
            w_tx_start_nxt = 1'b1;
            w_state_nxt    = S_TX_SEND;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
    w_busy_nxt      = (w_state_nxt != S_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_mem_type    <= 1'b0;
      r_byte_cnt    <= '0;
      r_lat_cnt     <= 3'd0;
      r_word        <= '0;
      r_cmd_ready   <= 1'b1;
      r_cmd_dropped <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_imem_we     <= 1'b0;
      r_dmem_we     <= 1'b0;
      r_imem_re     <= 1'b0;
      r_dmem_re     <= 1'b0;
      r_tx_data     <= 8'h00;
      r_tx_start    <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_mem_type    <= w_mem_type_nxt;
      r_byte_cnt    <= w_byte_cnt_nxt;
      r_lat_cnt     <= w_lat_cnt_nxt;
      r_word        <= w_word_nxt;
      r_cmd_ready   <= w_cmd_ready_nxt;
      r_cmd_dropped <= w_cmd_dropped_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_mem_wdata   <= w_mem_wdata_nxt;
      r_imem_we     <= w_imem_we_nxt;
      r_dmem_we     <= w_dmem_we_nxt;
      r_imem_re     <= w_imem_re_nxt;
      r_dmem_re     <= w_dmem_re_nxt;
      r_tx_data     <= w_tx_data_nxt;
      r_tx_start    <= w_tx_start_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

  assign o_cmd_ready   = r_cmd_ready;
  assign o_cmd_dropped = r_cmd_dropped;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wdata   = r_mem_wdata;
  assign o_imem_we     = r_imem_we;
  assign o_dmem_we     = r_dmem_we;
  assign o_imem_re     = r_imem_re;
  assign o_dmem_re     = r_dmem_re;
  assign o_tx_data     = r_tx_data;
  assign o_tx_start    = r_tx_start;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Directed bench for uart_mem_bridge: latency-1 instance for the main flows,
// latency-3 instance for read-capture timing.
module tb_uart_mem_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT 1 (latency 1) ----------------
  logic        cmd_valid_seq = 1'b0, cmd_valid_inj = 1'b0, cmd_valid;
  logic        cmd_rw = 1'b0, cmd_mem_type = 1'b0;
  logic [8:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        cmd_ready, cmd_dropped, imem_we, dmem_we, imem_re, dmem_re, tx_start, busy;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] imem_rdata = '0, dmem_rdata = '0;
  logic [7:0]  tx_data;
  logic        tx_done_m = 1'b0, tx_stray = 1'b0, tx_done;

  assign cmd_valid = cmd_valid_seq | cmd_valid_inj;
  assign tx_done   = tx_done_m | tx_stray;

  uart_mem_bridge #(.MEM_RD_LATENCY(1)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_cmd_valid(cmd_valid), .i_cmd_rw(cmd_rw), .i_cmd_mem_type(cmd_mem_type),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
    .o_cmd_ready(cmd_ready), .o_cmd_dropped(cmd_dropped),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_imem_we(imem_we), .o_dmem_we(dmem_we), .o_imem_re(imem_re), .o_dmem_re(dmem_re),
    .i_imem_rdata(imem_rdata), .i_dmem_rdata(dmem_rdata),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done(tx_done), .o_busy(busy)
  );

  // ---------------- DUT 2 (latency 3) ----------------
  logic        c2_valid = 1'b0, c2_rw = 1'b0, c2_type = 1'b0;
  logic [8:0]  c2_addr = '0;
  logic [31:0] c2_wdata = '0;
  logic        c2_ready, c2_dropped, c2_iwe, c2_dwe, c2_ire, c2_dre, c2_txs, c2_busy;
  logic [8:0]  c2_maddr;
  logic [31:0] c2_mwdata;
  logic [31:0] c2_irdata = 32'h0, c2_drdata = '0;
  logic [7:0]  c2_txd;
  logic        c2_txdone = 1'b0, c2_pend = 1'b0;

  uart_mem_bridge #(.MEM_RD_LATENCY(3)) dut3 (
    .i_clk(clk), .i_reset(rst),
    .i_cmd_valid(c2_valid), .i_cmd_rw(c2_rw), .i_cmd_mem_type(c2_type),
    .i_cmd_addr(c2_addr), .i_cmd_wdata(c2_wdata),
    .o_cmd_ready(c2_ready), .o_cmd_dropped(c2_dropped),
    .o_mem_addr(c2_maddr), .o_mem_wdata(c2_mwdata),
    .o_imem_we(c2_iwe), .o_dmem_we(c2_dwe), .o_imem_re(c2_ire), .o_dmem_re(c2_dre),
    .i_imem_rdata(c2_irdata), .i_dmem_rdata(c2_drdata),
    .o_tx_data(c2_txd), .o_tx_start(c2_txs), .i_tx_done(c2_txdone), .o_busy(c2_busy)
  );

  // ---------------- models and monitors (all on negedge) ----------------
  logic [31:0] imem_word = '0, dmem_word = '0;
  logic        ihist = 1'b0, dhist = 1'b0;
  logic [2:0]  d2hist = 3'b000;
  logic [7:0]  rx_q[$];
  logic [7:0]  q2[$];
  int n_iwe = 0, n_dwe = 0, n_ire = 0, n_dre = 0, n_txs = 0, n_drop = 0, n_excl = 0;
  int n_done = 0, last_done_cyc = 0, inj_at = -1, tx_timer = 0;
  int n2_txs = 0, n2_dre = 0;

  // Strobe counters and one-hot strobe check for DUT 1.
  always @(negedge clk) begin
    if (imem_we) n_iwe++;
    if (dmem_we) n_dwe++;
    if (imem_re) n_ire++;
    if (dmem_re) n_dre++;
    if (tx_start) n_txs++;
    if (cmd_dropped) n_drop++;
    if (int'(imem_we) + int'(dmem_we) + int'(imem_re) + int'(dmem_re) > 1) n_excl++;
  end

  // Latency-1 memories: data valid only in the cycle after the read strobe.
  always @(negedge clk) begin
    imem_rdata = ihist ? imem_word : (32'hBAD0_0000 + 32'(cyc));
    dmem_rdata = dhist ? dmem_word : (32'hDEAD_0000 + 32'(cyc));
    ihist = imem_re;
    dhist = dmem_re;
  end

  // Transmitter: tx_done four cycles after each tx_start; optional command injection
  // coincident with a chosen tx_done.
  always @(negedge clk) begin
    tx_done_m     = 1'b0;
    cmd_valid_inj = 1'b0;
    if (rst) begin
      tx_timer = 0;
    end else if (tx_start) begin
      rx_q.push_back(tx_data);
      tx_timer = 4;
    end else if (tx_timer > 0) begin
      tx_timer--;
      if (tx_timer == 0) begin
        tx_done_m = 1'b1;
        n_done++;
        last_done_cyc = cyc;
        if (n_done == inj_at) cmd_valid_inj = 1'b1;
      end
    end
  end

  // DUT 2 memory (latency 3, garbage otherwise) and transmitter (done one cycle later).
  always @(negedge clk) begin
    c2_drdata = d2hist[2] ? 32'h89AB_CDEF : (32'h5A5A_0000 + 32'(cyc));
    d2hist    = {d2hist[1:0], c2_dre};
    c2_txdone = c2_pend;
    c2_pend   = c2_txs;
    if (c2_txs) begin
      q2.push_back(c2_txd);
      n2_txs++;
    end
    if (c2_dre) n2_dre++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic rw, input logic mt, input logic [8:0] a, input logic [31:0] d);
    cmd_rw        = rw;
    cmd_mem_type  = mt;
    cmd_addr      = a;
    cmd_wdata     = d;
    cmd_valid_seq = 1'b1;
    @(negedge clk);
    cmd_valid_seq = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk_eq({tag, "_idle"}, 32'(busy), 0);
  endtask

  task automatic check_word(input string tag, input logic [31:0] w);
    logic [7:0] got;
    for (int i = 0; i < 4; i++) begin
      got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
      chk_eq($sformatf("%s_byte%0d", tag, i), 32'(got), 32'(w[31-8*i -: 8]));
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    int s_iwe, s_dwe, s_ire, s_dre, s_txs, s_drop, n, b;

    repeat (3) @(negedge clk);
    chk_eq("rst_ready", 32'(cmd_ready), 1);
    chk_eq("rst_busy", 32'(busy), 0);
    chk_eq("rst_addr", 32'(mem_addr), 0);
    chk_eq("rst_wdata", mem_wdata, 0);
    chk_eq("rst_txdata", 32'(tx_data), 0);
    chk_eq("rst_strobes", 32'({imem_we, dmem_we, imem_re, dmem_re, tx_start, cmd_dropped}), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: write dmem
    s_dwe = n_dwe; s_iwe = n_iwe; s_txs = n_txs;
    send_cmd(1'b1, 1'b1, 9'h005, 32'hDEADBEEF);
    chk_eq("t1_dmem_we", 32'(dmem_we), 1);
    chk_eq("t1_imem_we", 32'(imem_we), 0);
    chk_eq("t1_addr", 32'(mem_addr), 32'h005);
    chk_eq("t1_wdata", mem_wdata, 32'hDEADBEEF);
    chk_eq("t1_busy", 32'(busy), 1);
    @(negedge clk);
    chk_eq("t1_we_pulse", 32'(dmem_we), 0);
    chk_eq("t1_ready", 32'(cmd_ready), 1);
    repeat (3) @(negedge clk);
    chk_eq("t1_n_dwe", n_dwe - s_dwe, 1);
    chk_eq("t1_n_iwe", n_iwe - s_iwe, 0);
    chk_eq("t1_n_txs", n_txs - s_txs, 0);

    // 2: read imem, latency 1
    imem_word = 32'h12345678;
    rx_q.delete();
    s_ire = n_ire; s_dre = n_dre; s_txs = n_txs;
    send_cmd(1'b0, 1'b0, 9'h010, 32'h0);
    chk_eq("t2_imem_re", 32'(imem_re), 1);
    wait_idle("t2");
    b = cyc;
    chk_eq("t2_busy_fall", b, last_done_cyc + 1);
    chk_eq("t2_nbytes", rx_q.size(), 4);
    check_word("t2", 32'h12345678);
    chk_eq("t2_n_ire", n_ire - s_ire, 1);
    chk_eq("t2_n_dre", n_dre - s_dre, 0);
    chk_eq("t2_n_txs", n_txs - s_txs, 4);

    // 4: command while in TX_WAIT is dropped
    dmem_word = 32'hCAFEF00D;
    rx_q.delete();
    s_iwe = n_iwe; s_dwe = n_dwe; s_dre = n_dre; s_txs = n_txs; s_drop = n_drop;
    send_cmd(1'b0, 1'b1, 9'h020, 32'h0);
    n = 0;
    while ((n_txs - s_txs) < 1 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    send_cmd(1'b1, 1'b0, 9'h1FF, 32'h0BADC0DE);
    chk_eq("t4_dropped", 32'(cmd_dropped), 1);
    @(negedge clk);
    chk_eq("t4_drop_pulse", 32'(cmd_dropped), 0);
    wait_idle("t4");
    repeat (2) @(negedge clk);
    check_word("t4", 32'hCAFEF00D);
    chk_eq("t4_addr", 32'(mem_addr), 32'h020);
    chk_eq("t4_n_drop", n_drop - s_drop, 1);
    chk_eq("t4_n_we", (n_iwe - s_iwe) + (n_dwe - s_dwe), 0);
    chk_eq("t4_n_dre", n_dre - s_dre, 1);
    chk_eq("t4_n_txs", n_txs - s_txs, 4);

    // command coincident with the final tx_done is dropped
    dmem_word = 32'h0BADF00D;
    rx_q.delete();
    s_iwe = n_iwe; s_drop = n_drop;
    inj_at = n_done + 4;
    send_cmd(1'b0, 1'b1, 9'h030, 32'h0);
    cmd_rw = 1'b1; cmd_mem_type = 1'b0; cmd_addr = 9'h1FF; cmd_wdata = 32'h13579BDF;
    wait_idle("tc");
    repeat (3) @(negedge clk);
    inj_at = -1;
    chk_eq("tc_n_drop", n_drop - s_drop, 1);
    chk_eq("tc_n_iwe", n_iwe - s_iwe, 0);
    chk_eq("tc_busy", 32'(busy), 0);
    check_word("tc", 32'h0BADF00D);

    // 5: reset after second tx_start
    imem_word = 32'hA1B2C3D4;
    s_txs = n_txs;
    send_cmd(1'b0, 1'b0, 9'h044, 32'h0);
    n = 0;
    while ((n_txs - s_txs) < 2 && n < 200) begin @(negedge clk); n++; end
    chk_eq("t5_two_starts", n_txs - s_txs, 2);
    rst = 1'b1;
    #1;
    chk_eq("t5_busy", 32'(busy), 0);
    chk_eq("t5_ready", 32'(cmd_ready), 1);
    chk_eq("t5_strobes", 32'({imem_we, dmem_we, imem_re, dmem_re, tx_start, cmd_dropped}), 0);
    chk_eq("t5_addr", 32'(mem_addr), 0);
    chk_eq("t5_txdata", 32'(tx_data), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rx_q.delete();
    @(negedge clk);
    s_dwe = n_dwe; s_txs = n_txs;
    send_cmd(1'b1, 1'b1, 9'h007, 32'h01020304);
    chk_eq("t5_dmem_we", 32'(dmem_we), 1);
    chk_eq("t5_waddr", 32'(mem_addr), 32'h007);
    chk_eq("t5_wdata", mem_wdata, 32'h01020304);
    wait_idle("t5");
    repeat (3) @(negedge clk);
    chk_eq("t5_n_dwe", n_dwe - s_dwe, 1);
    chk_eq("t5_n_txs", n_txs - s_txs, 0);

    // 6: stray tx_done in idle, then back-to-back read/write/read
    s_txs = n_txs;
    tx_stray = 1'b1;
    @(negedge clk);
    tx_stray = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("t6_stray_txs", n_txs - s_txs, 0);
    chk_eq("t6_stray_busy", 32'(busy), 0);
    imem_word = 32'h11223344;
    dmem_word = 32'h99AABBCC;
    rx_q.delete();
    s_iwe = n_iwe; s_ire = n_ire; s_dre = n_dre; s_txs = n_txs;
    send_cmd(1'b0, 1'b0, 9'h100, 32'h0);
    wait_idle("t6a");
    send_cmd(1'b1, 1'b0, 9'h101, 32'h55667788);
    chk_eq("t6_imem_we", 32'(imem_we), 1);
    chk_eq("t6_waddr", 32'(mem_addr), 32'h101);
    chk_eq("t6_wdata", mem_wdata, 32'h55667788);
    wait_idle("t6b");
    send_cmd(1'b0, 1'b1, 9'h102, 32'h0);
    wait_idle("t6c");
    repeat (2) @(negedge clk);
    chk_eq("t6_nbytes", rx_q.size(), 8);
    check_word("t6_rd1", 32'h11223344);
    check_word("t6_rd2", 32'h99AABBCC);
    chk_eq("t6_n_iwe", n_iwe - s_iwe, 1);
    chk_eq("t6_n_ire", n_ire - s_ire, 1);
    chk_eq("t6_n_dre", n_dre - s_dre, 1);
    chk_eq("t6_n_txs", n_txs - s_txs, 8);

    // 3: latency-3 instance, garbage on rdata before the capture cycle
    c2_rw = 1'b0; c2_type = 1'b1; c2_addr = 9'h033; c2_valid = 1'b1;
    @(negedge clk);
    c2_valid = 1'b0;
    n = 0;
    while (c2_busy && n < 200) begin @(negedge clk); n++; end
    chk_eq("t3_idle", 32'(c2_busy), 0);
    chk_eq("t3_n_txs", n2_txs, 4);
    chk_eq("t3_n_dre", n2_dre, 1);
    for (int i = 0; i < 4; i++) begin
      chk_eq($sformatf("t3_byte%0d", i), 32'((q2.size() > i) ? q2[i] : 8'h00),
             32'((i == 0) ? 8'h89 : (i == 1) ? 8'hAB : (i == 2) ? 8'hCD : 8'hEF));
    end

    chk_eq("one_hot_strobes", n_excl, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
